arima_seq_ctrl: RTL and testbench
=================================

# arima_seq_ctrl

Sequencer for the ARIMA accelerator that owns configuration and sample streaming around `control_unit` and `data_path`. It holds a writable register file for orders, coefficients and frame length, and issues the `start` pulse. It then feeds exactly one frame of Q16.15 samples into the datapath with a valid/ready input handshake, and re-times `data_path.data_out` into a valid-qualified output stream using a latency-matched valid pipeline.

## Interface
- `LAT`, 3: cycles from a sample on `dp_data` to its result on `dp_out`.
- `MAX_ORDER`, 10: coefficient slots per polynomial.
- `LEN_W`, 16: width of the frame-length register.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  register write strobe.
- `cfg_addr`  in  5  register address.
- `cfg_wdata`  in  32  write data.
- `go`  in  1  one-cycle frame request.
- `s_valid`  in  1  input sample valid.
- `s_data`  in  32  signed Q16.15 input sample.
- `s_ready`  out  1  sample accepted when `s_valid && s_ready`.
- `p_order_in`, `d_order_in`, `q_order_in`, `cont_in`  out  32 each  config to `control_unit`.
- `ar_coef_in`, `ma_coef_in`  out  32 x `MAX_ORDER`  signed coefficient arrays to `control_unit`.
- `start`  out  1  one-cycle load pulse to `control_unit`.
- `dp_data`  out  32  sample driven to both `control_unit.data_in` and `data_path.data_in`.
- `dp_out`  in  32  `data_path.data_out`.
- `m_valid`  out  1  output result valid; there is no backpressure.
- `m_data`  out  32  result; equals `dp_out`.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse at frame end.
- `err_underrun`  out  1  sticky flag; cleared by the next accepted `go`.
- `err_cfg`  out  1  sticky flag; present only with the macro defined (see Configuration).

## Operation
- Register map:
  - 0 `p`, 1 `d`, 2 `q`, 3 `cont`.
  - 4..13 `ar[0..9]`, 14..23 `ma[0..9]`.
  - 24 `len` (low `LEN_W` bits).
  - 25..31: writes ignored.
- Writes take effect only in IDLE; writes in any other state are dropped.
- FSM states and transitions:
  - IDLE -> LOAD on `go`. With `len == 0`, `go` instead pulses `done` the next cycle and stays in IDLE.
  - LOAD (1 cycle): `start`=1 -> RUN.
  - RUN: `s_ready`=1. Each cycle, `dp_data` = `s_data` if `s_valid`, else 0. A cycle with `s_valid`=0 sets `err_underrun`; the bubble still counts as a sample because the datapath cannot stall. After `len` cycles -> DRAIN.
  - DRAIN: `LAT` cycles, `dp_data`=0 -> DONE.
  - DONE (1 cycle): `done`=1 -> IDLE.
- Valid pipeline: a shift register of depth `LAT` is loaded with 1 on every RUN cycle and 0 otherwise. `m_valid` is its tail, so exactly `len` results are emitted per frame.
- `go` outside IDLE is ignored.
- Config outputs are driven continuously from the registers.

## Timing
- Reset value of every output is 0; state is IDLE, all registers are 0, and the valid pipeline is cleared.
- `rst` mid-frame aborts the frame: no `done`, no further `m_valid`.
- `go` at cycle T:
  - `start` at T+1.
  - First sample consumed at T+2.
  - First `m_valid` at T+2+`LAT`.
  - Last `m_valid` at T+1+`len`+`LAT`.
  - `done` at T+2+`len`+`LAT`.
- `busy` is high from T+1 through the `done` cycle inclusive.
- The earliest next `go` that is accepted is the cycle after `done`.
- A `cfg_we` in the same cycle as an accepted `go` is applied; that write is included in the frame.

## Configuration
- `ARIMA_SEQ_CFG_CHECK_EN` defined:
  - On `go`, if `p` > `MAX_ORDER`, `q` > `MAX_ORDER`, or `d` > 2, the FSM sets `err_cfg`, does not pulse `start`, pulses `done` the next cycle, and stays in IDLE.
  - `err_cfg` is cleared by the next valid `go`.
- Undefined: no checking is performed, and `err_cfg` is tied to 0.

## Test plan
- Basic frame: configure p=2, d=1, q=2, ar={0x6000,0x1999}, ma={0x4000,0xFFFFE667}, len=8; `go` at T, with a ramp on the input held continuously valid. Required: `start` at T+1; eight `m_valid` cycles T+5..T+12 with `m_data` equal to `dp_out` at each; `done` at T+13; `err_underrun`=0.
- Underrun: as above, with `s_valid` dropped for one RUN cycle. Required: `dp_data`=0 in that cycle, `err_underrun`=1, still eight `m_valid` cycles, `done` at T+13.
- Config lockout: `cfg_we` to address 0 with data 5 during RUN, then read `p_order_in` after `done`. Required: value is still 2. A second `go` during RUN is ignored.
- Zero length: len=0, `go`. Required: no `start`, no `m_valid`, `done` one cycle later.
- Reset mid-frame: `rst` for one cycle at RUN sample 3. Required: all outputs 0 the next cycle, no `done`, and all registers read 0.
- With `ARIMA_SEQ_CFG_CHECK_EN`: p=11, `go`. Required: `err_cfg`=1, no `start`, `done` next cycle. Then p=2 and `go` clears `err_cfg` and the frame runs normally.

Source files
------------

// File: rtl/arima_seq_ctrl.sv
// ARIMA sequencer: config register file, start pulse, one-frame sample streaming and re-timed output valid.
// Optional order range check on go is enabled by defining ARIMA_SEQ_CFG_CHECK_EN.
module arima_seq_ctrl #(
   parameter int LAT       = 3,
   parameter int MAX_ORDER = 10,
   parameter int LEN_W     = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_we,
   input  logic [4:0]                 cfg_addr,
   input  logic [31:0]                cfg_wdata,
   input  logic                       go,
   input  logic                       s_valid,
   input  logic [31:0]                s_data,
   output logic                       s_ready,
   output logic [31:0]                p_order_in,
   output logic [31:0]                d_order_in,
   output logic [31:0]                q_order_in,
   output logic [31:0]                cont_in,
   output logic [MAX_ORDER-1:0][31:0] ar_coef_in,
   output logic [MAX_ORDER-1:0][31:0] ma_coef_in,
   output logic                       start,
   output logic [31:0]                dp_data,
   input  logic [31:0]                dp_out,
   output logic                       m_valid,
   output logic [31:0]                m_data,
   output logic                       busy,
   output logic                       done,
   output logic                       err_underrun,
   output logic                       err_cfg
);

   localparam int ADDR_AR0 = 4;
   localparam int ADDR_MA0 = 4 + MAX_ORDER;
   localparam int ADDR_LEN = 4 + 2 * MAX_ORDER;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

   state_t                     state, state_nxt;
   logic [31:0]                p_r, d_r, q_r, cont_r;
   logic [MAX_ORDER-1:0][31:0] ar_r, ma_r;
   logic [LEN_W-1:0]           len_r, len_eff, cnt;
   logic [LAT-1:0]             vpipe;
   logic                       cfg_wr, go_ok, cfg_bad;
   logic                       early_done, early_done_q, underrun_r;

   // A write landing in the same cycle as go must already count for that go's decisions.
   assign cfg_wr  = cfg_we && (state == IDLE);
   assign go_ok   = go && (state == IDLE) && !early_done_q;
   assign len_eff = (cfg_wr && cfg_addr == 5'(ADDR_LEN)) ? cfg_wdata[LEN_W-1:0] : len_r;

`ifdef ARIMA_SEQ_CFG_CHECK_EN
   logic [31:0] p_eff, d_eff, q_eff;
   logic        err_cfg_r;

   assign p_eff   = (cfg_wr && cfg_addr == 5'd0) ? cfg_wdata : p_r;
   assign d_eff   = (cfg_wr && cfg_addr == 5'd1) ? cfg_wdata : d_r;
   assign q_eff   = (cfg_wr && cfg_addr == 5'd2) ? cfg_wdata : q_r;
   assign cfg_bad = (p_eff > 32'(MAX_ORDER)) || (q_eff > 32'(MAX_ORDER)) || (d_eff > 32'd2);

   always_ff @(posedge clk) begin
      if (rst)
         err_cfg_r <= 1'b0;
      else if (go_ok)
         err_cfg_r <= cfg_bad;
   end

   assign err_cfg = err_cfg_r;
`else
   assign cfg_bad = 1'b0;
   assign err_cfg = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      s_ready    = 1'b0;
      early_done = 1'b0;
      case (state)
         IDLE: begin
            if (go_ok) begin
               if (cfg_bad || len_eff == '0)
                  early_done = 1'b1;
               else
                  state_nxt = LOAD;
            end
         end
         LOAD: begin
            start     = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            s_ready = 1'b1;
            if (cnt == LEN_W'(1))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (cnt == '0)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One counter serves both phases: samples left in RUN, then flush cycles left in DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         vpipe        <= '0;
         early_done_q <= 1'b0;
         underrun_r   <= 1'b0;
      end else begin
         early_done_q <= early_done;
         vpipe        <= LAT'({vpipe, state == RUN});
         case (state)
            LOAD:    cnt <= len_r;
            RUN:     cnt <= (cnt == LEN_W'(1)) ? LEN_W'(LAT - 1) : cnt - LEN_W'(1);
            DRAIN:   cnt <= cnt - LEN_W'(1);
            default: cnt <= cnt;
         endcase
         if (go_ok)
            underrun_r <= 1'b0;
         else if (state == RUN && !s_valid)
            underrun_r <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_r    <= '0;
         d_r    <= '0;
         q_r    <= '0;
         cont_r <= '0;
         ar_r   <= '0;
         ma_r   <= '0;
         len_r  <= '0;
      end else if (cfg_wr) begin
         case (cfg_addr)
            5'd0:    p_r    <= cfg_wdata;
            5'd1:    d_r    <= cfg_wdata;
            5'd2:    q_r    <= cfg_wdata;
            5'd3:    cont_r <= cfg_wdata;
            default: ;
         endcase
         for (int i = 0; i < MAX_ORDER; i++) begin
            if (cfg_addr == 5'(ADDR_AR0 + i))
               ar_r[i] <= cfg_wdata;
            if (cfg_addr == 5'(ADDR_MA0 + i))
               ma_r[i] <= cfg_wdata;
         end
         if (cfg_addr == 5'(ADDR_LEN))
            len_r <= cfg_wdata[LEN_W-1:0];
      end
   end

   assign p_order_in   = p_r;
   assign d_order_in   = d_r;
   assign q_order_in   = q_r;
   assign cont_in      = cont_r;
   assign ar_coef_in   = ar_r;
   assign ma_coef_in   = ma_r;
   assign dp_data      = (state == RUN && s_valid) ? s_data : '0;
   assign m_valid      = vpipe[LAT-1];
   assign m_data       = m_valid ? dp_out : '0;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE) || early_done_q;
   assign err_underrun = underrun_r;

endmodule

// File: tb/tb_arima_seq_ctrl.sv
// Self-checking bench for arima_seq_ctrl: frame timing derived from go-relative cycle arithmetic,
// with a behavioural LAT-cycle datapath stand-in feeding dp_out.
module tb_arima_seq_ctrl;

   localparam int LAT       = 3;
   localparam int MAX_ORDER = 10;
   localparam int LEN_W     = 16;
   localparam logic [31:0] DP_OFFSET = 32'h0001_0000;

   logic                       clk = 1'b0;
   logic                       rst, cfg_we, go, s_valid;
   logic [4:0]                 cfg_addr;
   logic [31:0]                cfg_wdata, s_data;
   logic                       s_ready, start, m_valid, busy, done, err_underrun, err_cfg;
   logic [31:0]                p_order_in, d_order_in, q_order_in, cont_in;
   logic [MAX_ORDER-1:0][31:0] ar_coef_in, ma_coef_in;
   logic [31:0]                dp_data, dp_out, m_data;

   logic [31:0] hist [LAT];
   logic [31:0] cfg_model [32];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   arima_seq_ctrl #(.LAT(LAT), .MAX_ORDER(MAX_ORDER), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .go(go), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .p_order_in(p_order_in), .d_order_in(d_order_in), .q_order_in(q_order_in), .cont_in(cont_in),
      .ar_coef_in(ar_coef_in), .ma_coef_in(ma_coef_in), .start(start), .dp_data(dp_data),
      .dp_out(dp_out), .m_valid(m_valid), .m_data(m_data), .busy(busy), .done(done),
      .err_underrun(err_underrun), .err_cfg(err_cfg)
   );

   // Stand-in for data_path: a fixed transform of each sample, LAT cycles later.
   always @(posedge clk) begin
      hist[0] <= dp_data;
      for (int j = 1; j < LAT; j++)
         hist[j] <= hist[j-1];
   end
   assign dp_out = hist[LAT-1] + DP_OFFSET;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic go_v, input logic we_v, input logic [4:0] addr_v,
                                input logic [31:0] wdata_v, input logic sv_v,
                                input logic [31:0] sd_v, input logic rst_v);
      @(posedge clk);
      #1;
      go        = go_v;
      cfg_we    = we_v;
      cfg_addr  = addr_v;
      cfg_wdata = wdata_v;
      s_valid   = sv_v;
      s_data    = sd_v;
      rst       = rst_v;
      @(negedge clk);
   endtask

   task automatic writeCfg(input logic [4:0] addr, input logic [31:0] data);
      applyStimulus(1'b0, 1'b1, addr, data, 1'b0, 32'd0, 1'b0);
      if (addr <= 5'd24)
         cfg_model[addr] = data;
   endtask

   task automatic checkConfig(input string tag);
      checkOutput({tag, "_p"}, p_order_in, cfg_model[0]);
      checkOutput({tag, "_d"}, d_order_in, cfg_model[1]);
      checkOutput({tag, "_q"}, q_order_in, cfg_model[2]);
      checkOutput({tag, "_cont"}, cont_in, cfg_model[3]);
      for (int i = 0; i < MAX_ORDER; i++) begin
         checkOutput({tag, "_ar"}, ar_coef_in[i], cfg_model[4+i]);
         checkOutput({tag, "_ma"}, ma_coef_in[i], cfg_model[14+i]);
      end
   endtask

   // Cycle k is counted from the go cycle; every output is predicted from that offset alone.
   task automatic runFrame(input int drop_at, input int we_k, input logic [4:0] we_addr,
                           input logic [31:0] we_data, input int extra_go_k, input bit go_at_done);
      logic [31:0] sent [$];
      int          len, done_k;
      bit          run, mv, gv, wv;
      logic        sv;
      logic [31:0] sd;
      if (we_k == 0 && we_addr <= 5'd24)
         cfg_model[we_addr] = we_data;
      len    = int'(cfg_model[24][LEN_W-1:0]);
      done_k = 2 + len + LAT;
      for (int k = 0; k <= done_k + 1; k++) begin
         run = (k >= 2) && (k <= len + 1);
         gv  = (k == 0) || (k == extra_go_k) || (go_at_done && k == done_k);
         wv  = (k == we_k);
         sd  = $urandom;
         sv  = run ? (k - 2 != drop_at) : 1'($urandom_range(0, 1));
         if (run)
            sent.push_back(sv ? sd : 32'd0);
         applyStimulus(gv, wv, we_addr, we_data, sv, sd, 1'b0);
         mv = (k >= 2 + LAT) && (k <= 1 + len + LAT);
         checkOutput("start", 32'(start), 32'(k == 1));
         checkOutput("s_ready", 32'(s_ready), 32'(run));
         checkOutput("dp_data", dp_data, run ? sent[k-2] : 32'd0);
         checkOutput("m_valid", 32'(m_valid), 32'(mv));
         checkOutput("m_data", m_data, mv ? sent[k-2-LAT] + DP_OFFSET : 32'd0);
         checkOutput("done", 32'(done), 32'(k == done_k));
         checkOutput("busy", 32'(busy), 32'((k >= 1) && (k <= done_k)));
      end
      checkOutput("err_underrun", 32'(err_underrun), 32'((drop_at >= 0) && (drop_at < len)));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int newlen, drop;
      rst = 1'b1; go = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; s_valid = 1'b0; s_data = '0;
      for (int i = 0; i < 32; i++)
         cfg_model[i] = 32'd0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_start", 32'(start), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_m_data", m_data, 32'd0);
      checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
      checkOutput("rst_err_underrun", 32'(err_underrun), 32'd0);
      checkOutput("rst_err_cfg", 32'(err_cfg), 32'd0);
      checkConfig("rst");

      $display("[TB] basic frame");
      writeCfg(5'd0, 32'd2);
      writeCfg(5'd1, 32'd1);
      writeCfg(5'd2, 32'd2);
      writeCfg(5'd3, 32'd1);
      writeCfg(5'd4, 32'h0000_6000);
      writeCfg(5'd5, 32'h0000_1999);
      writeCfg(5'd14, 32'h0000_4000);
      writeCfg(5'd15, 32'hFFFF_E667);
      writeCfg(5'd24, 32'd8);
      writeCfg(5'd27, 32'hDEAD_BEEF);
      checkConfig("cfg");
      runFrame(-1, -1, 5'd0, 32'd0, -1, 1'b0);

      $display("[TB] underrun frame");
      runFrame(int'($urandom_range(0, 7)), -1, 5'd0, 32'd0, -1, 1'b0);

      $display("[TB] config lockout, ignored go in RUN and at done");
      runFrame(-1, 5, 5'd0, 32'd5, 6, 1'b1);
      checkConfig("lock");

      $display("[TB] randomized frames");
      for (int n = 0; n < 4; n++) begin
         writeCfg(5'd0, 32'($urandom_range(0, 10)));
         writeCfg(5'd1, 32'($urandom_range(0, 2)));
         writeCfg(5'd2, 32'($urandom_range(0, 10)));
         writeCfg(5'(4 + $urandom_range(0, 19)), $urandom);
         writeCfg(5'd24, 32'($urandom_range(1, 12)));
         newlen = int'($urandom_range(1, 10));
         drop   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, newlen - 1)) : -1;
         runFrame(drop, 0, 5'd24, 32'(newlen), -1, 1'b0);
         checkConfig("rand");
      end

      $display("[TB] zero length");
      writeCfg(5'd24, 32'd0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(k == 0, 1'b0, 5'd0, 32'd0, 1'b1, $urandom, 1'b0);
         checkOutput("zl_start", 32'(start), 32'd0);
         checkOutput("zl_s_ready", 32'(s_ready), 32'd0);
         checkOutput("zl_m_valid", 32'(m_valid), 32'd0);
         checkOutput("zl_done", 32'(done), 32'(k == 1));
         checkOutput("zl_busy", 32'(busy), 32'd0);
      end

`ifdef ARIMA_SEQ_CFG_CHECK_EN
      $display("[TB] config check");
      writeCfg(5'd24, 32'd4);
      writeCfg(5'd0, 32'd11);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(k == 0, 1'b0, 5'd0, 32'd0, 1'b1, $urandom, 1'b0);
         checkOutput("cc_start", 32'(start), 32'd0);
         checkOutput("cc_done", 32'(done), 32'(k == 1));
         checkOutput("cc_busy", 32'(busy), 32'd0);
         checkOutput("cc_err_cfg", 32'(err_cfg), 32'(k >= 1));
      end
      writeCfg(5'd0, 32'd2);
      checkOutput("cc_err_cfg_hold", 32'(err_cfg), 32'd1);
      runFrame(-1, -1, 5'd0, 32'd0, -1, 1'b0);
      checkOutput("cc_err_cfg_clr", 32'(err_cfg), 32'd0);
`endif

      $display("[TB] reset mid-frame");
      writeCfg(5'd24, 32'd8);
      for (int k = 0; k <= 20; k++) begin
         applyStimulus(k == 0, 1'b0, 5'd0, 32'd0, 1'b1, $urandom, k == 5);
         if (k == 4)
            checkOutput("mr_busy_pre", 32'(busy), 32'd1);
         if (k >= 6) begin
            checkOutput("mr_start", 32'(start), 32'd0);
            checkOutput("mr_s_ready", 32'(s_ready), 32'd0);
            checkOutput("mr_dp_data", dp_data, 32'd0);
            checkOutput("mr_m_valid", 32'(m_valid), 32'd0);
            checkOutput("mr_m_data", m_data, 32'd0);
            checkOutput("mr_done", 32'(done), 32'd0);
            checkOutput("mr_busy", 32'(busy), 32'd0);
            checkOutput("mr_err_underrun", 32'(err_underrun), 32'd0);
         end
      end
      for (int i = 0; i < 32; i++)
         cfg_model[i] = 32'd0;
      checkConfig("mr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
